pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 3, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall/flush counter width.
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired, never a hazard or forward source.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port id_valid, input, 1, instruction present in ID.
REQ-007 SHALL have ports id_rs and id_rt, input, REG_AW each, ID source registers.
REQ-008 SHALL have ports id_use_rs and id_use_rt, input, 1 each, source actually read.
REQ-009 SHALL have port id_rd, input, REG_AW, ID destination register (post-regdst).
REQ-010 SHALL have ports id_regwrite and id_memread, input, 1 each, ID control bits.
REQ-011 SHALL have port ex_branch_taken, input, 1, branch in EX resolved taken this cycle.
REQ-012 SHALL have port stall, output, 1, hold PC and IF/ID.
REQ-013 SHALL have port flush_if_id, output, 1, squash IF/ID.
REQ-014 SHALL have port bubble_id_ex, output, 1, load NOP into ID/EX.
REQ-015 SHALL have ports fwd_a and fwd_b, output, 2 each, EX operand select: 0 = regfile, 1 = EX/MEM ALU result, 2 = MEM/WB write data.
REQ-016 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each, event counters.

Function
REQ-017 SHALL keep three internal slots (EX, MEM, WB), each holding valid, rs, rt, use_rs, use_rt, rd, regwrite, memread.
REQ-018 SHALL advance MEM->WB and EX->MEM every cycle unconditionally.
REQ-019 SHALL load the EX slot from the ID inputs when id_valid and not bubble_id_ex; otherwise EX slot valid <= 0.
REQ-020 SHALL treat a slot as a write source only if valid, regwrite, and (ZERO_REG==0 or rd != 0).
REQ-021 SHALL assert stall combinationally (load-use) when id_valid, EX slot is a write source with memread, and rd matches id_rs with id_use_rs or id_rt with id_use_rt.
REQ-022 Load-use stall SHALL last exactly one cycle; on the following cycle the load is in MEM and no new stall is raised for it.
REQ-023 On stall, bubble_id_ex SHALL be 1 and flush_if_id SHALL be 0.
REQ-024 On ex_branch_taken, flush_if_id = 1, bubble_id_ex = 1, stall = 0; branch overrides a simultaneous load-use stall and kills the stalled ID instruction.
REQ-025 fwd_a SHALL be 1 if EX slot use_rs and MEM slot is a non-load write source with rd == EX rs; else 2 if WB slot is a write source with rd == EX rs; else 0. fwd_b likewise for rt.
REQ-026 EX/MEM match SHALL take priority over MEM/WB match.
REQ-027 fwd_a/fwd_b SHALL be 0 when the EX slot is invalid.
REQ-028 MEM-slot load matching the EX source SHALL never select 1; REQ-021 guarantees WB forwarding instead.
REQ-029 stall_cnt SHALL increment on each cycle stall = 1; flush_cnt on each cycle flush_if_id = 1; both saturate at all-ones.
REQ-030 Outputs stall, flush_if_id, bubble_id_ex, fwd_a, fwd_b SHALL be combinational from current slots and inputs; zero-cycle latency.

Reset
REQ-031 reset low SHALL immediately clear all slot valid bits and both counters; stall, flush_if_id, bubble_id_ex, fwd_a, fwd_b read 0 while reset is low.
REQ-032 reset assertion mid-stall SHALL abandon the stall; the first cycle after release treats the pipeline as empty.
REQ-033 Release of reset SHALL take effect on the first rising clk after reset goes high.

Verification
REQ-034 EX-to-EX forward: issue add r3 (rd=3, regwrite), then consumer rs=3 -> next cycle fwd_a=1, stall=0.
REQ-035 MEM/WB forward and priority: producers r3 at t and t+1, consumer rs=rt=3 at t+2 -> fwd_a=fwd_b=1; with only the older producer -> 2.
REQ-036 Load-use: lw rd=2 then consumer rt=2 -> stall=1, bubble_id_ex=1 for one cycle, then fwd_b=2 in EX; stall_cnt=1.
REQ-037 Branch over stall: load-use stall and ex_branch_taken in same cycle -> stall=0, flush_if_id=1, bubble_id_ex=1, flush_cnt=1.
REQ-038 Zero register: ZERO_REG=1, producer rd=0 then consumer rs=0 -> fwd_a=0, no stall; ZERO_REG=0 -> fwd_a=1.
REQ-039 Reset mid-operation and saturation: reset low during stall -> all outputs 0 at once; CNT_W=2 with 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and forwarding unit for a classic 5-stage pipeline.
// Tracks the instructions in EX, MEM and WB as three shadow slots and
// derives load-use stalls, branch flushes and operand forwarding selects
// combinationally from those slots and the instruction currently in ID.
module pipe_hazard_unit #(
    parameter int REG_AW   = 3,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush_if_id,
    output logic              bubble_id_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } slot_t;

    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    slot_t            slot_q [3];
    slot_t            slot_d [3];
    logic [2:0]       wsrc;
    logic             load_use;
    logic [1:0]       fwd_sel [2];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // A slot only produces a value worth forwarding/stalling on if it
    // really writes a register other than the hardwired zero register.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_wsrc
            assign wsrc[gi] = slot_q[gi].valid & slot_q[gi].regwrite &
                              ((ZERO_REG == 0) | (slot_q[gi].rd != '0));
        end
    endgenerate

    // Load in EX whose destination is read by ID: the value is not ready
    // until the load reaches WB, so ID must wait one cycle.
    always_comb begin
        load_use = id_valid & wsrc[EX] & slot_q[EX].memread &
                   (((slot_q[EX].rd == id_rs) & id_use_rs) |
                    ((slot_q[EX].rd == id_rt) & id_use_rt));
    end

    // Pipeline control; a taken branch wins over a load-use stall because
    // the stalled ID instruction is on the wrong path anyway.
    always_comb begin
        stall        = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        if (reset) begin
            if (ex_branch_taken) begin
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (load_use) begin
                stall        = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    // Operand forwarding for rs (gi=0) and rt (gi=1). The younger producer
    // in MEM wins over WB; a load in MEM has no ALU result to forward, and
    // the load-use stall guarantees it is picked up from WB instead.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [REG_AW-1:0] src;
            logic              use_src;
            assign src     = (gi == 0) ? slot_q[EX].rs : slot_q[EX].rt;
            assign use_src = (gi == 0) ? slot_q[EX].use_rs : slot_q[EX].use_rt;

            // Select the freshest available copy of this source operand.
            always_comb begin
                fwd_sel[gi] = 2'd0;
                if (reset && slot_q[EX].valid && use_src) begin
                    if (wsrc[MEM] && !slot_q[MEM].memread && slot_q[MEM].rd == src)
                        fwd_sel[gi] = 2'd1;
                    else if (wsrc[WB] && slot_q[WB].rd == src)
                        fwd_sel[gi] = 2'd2;
                end
            end
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    // Slot advance: MEM->WB and EX->MEM always; ID->EX unless bubbled.
    always_comb begin
        slot_d[WB]          = slot_q[MEM];
        slot_d[MEM]         = slot_q[EX];
        slot_d[EX].valid    = id_valid & ~bubble_id_ex;
        slot_d[EX].rs       = id_rs;
        slot_d[EX].rt       = id_rt;
        slot_d[EX].use_rs   = id_use_rs;
        slot_d[EX].use_rt   = id_use_rt;
        slot_d[EX].rd       = id_rd;
        slot_d[EX].regwrite = id_regwrite;
        slot_d[EX].memread  = id_memread;
    end

    // Slot registers; reset empties the pipeline immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) slot_q[i] <= slot_d[i];
        end
    end

    // Saturating event counter next-state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_if_id && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // Event counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: three instances (default, ZERO_REG=0, CNT_W=2)
// share one input stream; each is compared every cycle with an
// instruction-history model, plus directed checks with fixed values.
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, ex_branch_taken;
    logic [2:0] id_rs, id_rt, id_rd;

    logic        st_m, fl_m, bb_m, st_z, fl_z, bb_z, st_s, fl_s, bb_s;
    logic [1:0]  fa_m, fb_m, fa_z, fb_z, fa_s, fb_s;
    logic [15:0] sc_m, fc_m, sc_z, fc_z;
    logic [1:0]  sc_s, fc_s;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.REG_AW(3), .CNT_W(16), .ZERO_REG(1)) u_main (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
        .stall(st_m), .flush_if_id(fl_m), .bubble_id_ex(bb_m), .fwd_a(fa_m), .fwd_b(fb_m),
        .stall_cnt(sc_m), .flush_cnt(fc_m));

    pipe_hazard_unit #(.REG_AW(3), .CNT_W(16), .ZERO_REG(0)) u_zr0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
        .stall(st_z), .flush_if_id(fl_z), .bubble_id_ex(bb_z), .fwd_a(fa_z), .fwd_b(fb_z),
        .stall_cnt(sc_z), .flush_cnt(fc_z));

    pipe_hazard_unit #(.REG_AW(3), .CNT_W(2), .ZERO_REG(1)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
        .stall(st_s), .flush_if_id(fl_s), .bubble_id_ex(bb_s), .fwd_a(fa_s), .fwd_b(fb_s),
        .stall_cnt(sc_s), .flush_cnt(fc_s));

    // One issued instruction as seen by the reference model.
    typedef struct {
        bit v;
        int rs;
        int rt;
        bit urs;
        bit urt;
        int rd;
        bit rw;
        bit mr;
    } ins_t;

    // History of instructions that entered EX: [0]=EX, [1]=MEM, [2]=WB.
    ins_t hm [3];
    ins_t hz [3];
    int   sm, fm, sz, fz;
    ins_t cur_id;
    bit   cur_br;
    int   checks = 0;
    int   errors = 0;

    function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt, int rd, bit rw, bit mr);
        ins_t i;
        i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt; i.rd = rd; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic bit writes(ins_t i, bit zr);
        return i.v && i.rw && (!zr || i.rd != 0);
    endfunction

    function automatic bit must_wait(ins_t ex, ins_t id, bit zr);
        return id.v && writes(ex, zr) && ex.mr &&
               ((id.urs && id.rs == ex.rd) || (id.urt && id.rt == ex.rd));
    endfunction

    // Where the EX operand's freshest value lives.
    function automatic int source_of(ins_t ex, ins_t mem, ins_t wb, int r, bit used, bit zr);
        if (!ex.v || !used) return 0;
        if (writes(mem, zr) && !mem.mr && mem.rd == r) return 1;
        if (writes(wb, zr) && wb.rd == r) return 2;
        return 0;
    endfunction

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut(string n, ins_t ex, ins_t mem, ins_t wb, bit zr, int sc, int fc, int cmax,
                             logic st, logic fl, logic bb, logic [1:0] fa, logic [1:0] fb,
                             logic [15:0] osc, logic [15:0] ofc);
        bit lu;
        int es, ef, eb, ea, ebb;
        es = 0; ef = 0; eb = 0; ea = 0; ebb = 0;
        if (reset) begin
            lu  = must_wait(ex, cur_id, zr);
            ef  = cur_br ? 1 : 0;
            es  = (lu && !cur_br) ? 1 : 0;
            eb  = (lu || cur_br) ? 1 : 0;
            ea  = source_of(ex, mem, wb, ex.rs, ex.urs, zr);
            ebb = source_of(ex, mem, wb, ex.rt, ex.urt, zr);
        end
        chk({n, "_stall"}, {31'd0, st}, es);
        chk({n, "_flush"}, {31'd0, fl}, ef);
        chk({n, "_bubble"}, {31'd0, bb}, eb);
        chk({n, "_fwd_a"}, {30'd0, fa}, ea);
        chk({n, "_fwd_b"}, {30'd0, fb}, ebb);
        chk({n, "_stall_cnt"}, {16'd0, osc}, min_i(sc, cmax));
        chk({n, "_flush_cnt"}, {16'd0, ofc}, min_i(fc, cmax));
    endtask

    task automatic check_all();
        check_dut("main", hm[0], hm[1], hm[2], 1'b1, sm, fm, 65535, st_m, fl_m, bb_m, fa_m, fb_m, sc_m, fc_m);
        check_dut("zr0", hz[0], hz[1], hz[2], 1'b0, sz, fz, 65535, st_z, fl_z, bb_z, fa_z, fb_z, sc_z, fc_z);
        check_dut("sat", hm[0], hm[1], hm[2], 1'b1, sm, fm, 3, st_s, fl_s, bb_s, fa_s, fb_s,
                  {14'd0, sc_s}, {14'd0, fc_s});
    endtask

    // Present an instruction in ID (and branch outcome), then check mid-cycle.
    task automatic drive(ins_t id, bit br);
        cur_id = id; cur_br = br;
        id_valid = id.v; id_rs = id.rs[2:0]; id_rt = id.rt[2:0];
        id_use_rs = id.urs; id_use_rt = id.urt; id_rd = id.rd[2:0];
        id_regwrite = id.rw; id_memread = id.mr; ex_branch_taken = br;
        @(negedge clk);
        check_all();
    endtask

    // Clock edge: advance the model histories exactly as the rules say.
    task automatic tick();
        bit lm, lz;
        @(posedge clk);
        if (reset) begin
            lm = must_wait(hm[0], cur_id, 1'b1);
            lz = must_wait(hz[0], cur_id, 1'b0);
            if (lm && !cur_br) sm++;
            if (lz && !cur_br) sz++;
            if (cur_br) begin fm++; fz++; end
            hm[2] = hm[1]; hm[1] = hm[0];
            hm[0] = (cur_id.v && !lm && !cur_br) ? cur_id : mk(0, 0, 0, 0, 0, 0, 0, 0);
            hz[2] = hz[1]; hz[1] = hz[0];
            hz[0] = (cur_id.v && !lz && !cur_br) ? cur_id : mk(0, 0, 0, 0, 0, 0, 0, 0);
        end
        #1;
    endtask

    task automatic reset_now();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hm[i] = mk(0, 0, 0, 0, 0, 0, 0, 0);
            hz[i] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        end
        sm = 0; fm = 0; sz = 0; fz = 0;
        #1;
        check_all();
    endtask

    initial begin
        ins_t nop, lw, cons;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin hm[i] = nop; hz[i] = nop; end
        sm = 0; fm = 0; sz = 0; fz = 0;

        // Reset state, with a branch pending to prove outputs stay quiet.
        cur_id = mk(1, 1, 2, 1, 1, 3, 1, 0); cur_br = 1'b1;
        id_valid = 1; id_rs = 1; id_rt = 2; id_use_rs = 1; id_use_rt = 1; id_rd = 3;
        id_regwrite = 1; id_memread = 0; ex_branch_taken = 1;
        #2 check_all();
        @(posedge clk); #1;
        check_all();
        reset = 1'b1;

        // EX-to-EX forward.
        drive(mk(1, 1, 2, 1, 1, 3, 1, 0), 0); tick();
        drive(mk(1, 3, 4, 1, 0, 5, 1, 0), 0); chk("e2e_stall", {31'd0, st_m}, 0); tick();
        drive(nop, 0); chk("e2e_fwd_a", {30'd0, fa_m}, 1); tick();
        repeat (3) begin drive(nop, 0); tick(); end

        // Two producers: youngest wins; only the older one -> WB forward.
        drive(mk(1, 1, 1, 1, 1, 3, 1, 0), 0); tick();
        drive(mk(1, 2, 2, 1, 1, 3, 1, 0), 0); tick();
        drive(mk(1, 3, 3, 1, 1, 6, 1, 0), 0); tick();
        drive(nop, 0);
        chk("prio_fwd_a", {30'd0, fa_m}, 1); chk("prio_fwd_b", {30'd0, fb_m}, 1); tick();
        repeat (3) begin drive(nop, 0); tick(); end
        drive(mk(1, 1, 1, 1, 1, 3, 1, 0), 0); tick();
        drive(mk(1, 2, 2, 1, 1, 5, 1, 0), 0); tick();
        drive(mk(1, 3, 3, 1, 1, 6, 1, 0), 0); tick();
        drive(nop, 0);
        chk("wb_fwd_a", {30'd0, fa_m}, 2); chk("wb_fwd_b", {30'd0, fb_m}, 2); tick();
        repeat (3) begin drive(nop, 0); tick(); end

        // Load-use: one stall cycle, then WB forward.
        lw   = mk(1, 1, 0, 1, 0, 2, 1, 1);
        cons = mk(1, 5, 2, 0, 1, 7, 1, 0);
        drive(lw, 0); tick();
        drive(cons, 0);
        chk("lu_stall", {31'd0, st_m}, 1); chk("lu_bubble", {31'd0, bb_m}, 1); tick();
        drive(cons, 0); chk("lu_stall_once", {31'd0, st_m}, 0); tick();
        drive(nop, 0);
        chk("lu_fwd_b", {30'd0, fb_m}, 2); chk("lu_stall_cnt", {16'd0, sc_m}, 1); tick();
        repeat (3) begin drive(nop, 0); tick(); end

        // Branch overrides a simultaneous load-use stall.
        drive(mk(1, 1, 0, 1, 0, 4, 1, 1), 0); tick();
        drive(mk(1, 4, 0, 1, 0, 5, 1, 0), 1);
        chk("br_stall", {31'd0, st_m}, 0); chk("br_flush", {31'd0, fl_m}, 1);
        chk("br_bubble", {31'd0, bb_m}, 1); tick();
        drive(nop, 0); chk("br_flush_cnt", {16'd0, fc_m}, 1); tick();
        repeat (3) begin drive(nop, 0); tick(); end

        // Register 0 hardwired versus ordinary.
        drive(mk(1, 1, 1, 1, 0, 0, 1, 0), 0); tick();
        drive(mk(1, 0, 1, 1, 0, 6, 1, 0), 0); tick();
        drive(nop, 0);
        chk("zr_fwd_a_main", {30'd0, fa_m}, 0); chk("zr_fwd_a_zr0", {30'd0, fa_z}, 1); tick();
        drive(mk(1, 1, 1, 1, 0, 0, 1, 1), 0); tick();
        drive(mk(1, 0, 1, 1, 0, 6, 1, 0), 0);
        chk("zr_stall_main", {31'd0, st_m}, 0); chk("zr_stall_zr0", {31'd0, st_z}, 1); tick();
        repeat (3) begin drive(nop, 0); tick(); end

        // Reset during a stall abandons it; pipeline empty after release.
        drive(lw, 0); tick();
        drive(cons, 0); chk("rst_pre_stall", {31'd0, st_m}, 1);
        reset_now();
        chk("rst_stall", {31'd0, st_m}, 0); chk("rst_bubble", {31'd0, bb_m}, 0);
        tick();
        reset = 1'b1;
        drive(cons, 0); chk("rst_after_stall", {31'd0, st_m}, 0); tick();
        repeat (3) begin drive(nop, 0); tick(); end

        // Five load-use stalls: 2-bit counter saturates at 3.
        repeat (5) begin
            drive(mk(1, 0, 0, 0, 0, 1, 1, 1), 0); tick();
            drive(mk(1, 1, 0, 1, 0, 2, 1, 0), 0); tick();
            drive(nop, 0); tick();
        end
        drive(nop, 0);
        chk("sat_stall_cnt", {30'd0, sc_s}, 3); chk("main_stall_cnt5", {16'd0, sc_m}, 5); tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            ins_t r;
            r = mk($urandom_range(9, 0) != 0, $urandom_range(3, 0), $urandom_range(3, 0),
                   $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(3, 0),
                   $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0);
            drive(r, $urandom_range(9, 0) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
